// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding word-bus access per instruction, with stall, lane steering and fault reporting.
// Optional bus timeout abort is compiled in with `define LSU_TIMEOUT_EN.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_write_data,
    input  logic        i_ctrl_mem_write,
    input  logic        i_ctrl_mem2reg,
    input  logic [2:0]  i_ctrl_word_size,
    output logic        o_stall,
    output logic [31:0] o_load_data,
    output logic        o_fault,
    output logic        o_timeout,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t      state;
    logic        access_p0;
    logic        legal_p0;
    logic        store_p0;
    logic [2:0]  size_p1;
    logic [1:0]  lane_p1;

    function automatic logic access_legal(input logic [2:0] size, input logic [1:0] lo);
        case (size)
            3'b000, 3'b100: access_legal = 1'b1;
            3'b001, 3'b101: access_legal = ~lo[0];
            3'b010:         access_legal = (lo == 2'b00);
            default:        access_legal = 1'b0;
        endcase
    endfunction

    // Only called for legal sizes, so size[1:0] alone separates B, H and W.
    function automatic logic [3:0] lane_enables(input logic [2:0] size, input logic [1:0] lo);
        case (size[1:0])
            2'b00:   lane_enables = 4'b0001 << lo;
            2'b01:   lane_enables = lo[1] ? 4'b1100 : 4'b0011;
            default: lane_enables = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [2:0] size, input logic [31:0] data);
        case (size[1:0])
            2'b00:   replicate = {4{data[7:0]}};
            2'b01:   replicate = {2{data[15:0]}};
            default: replicate = data;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [2:0] size, input logic [1:0] lo,
                                                input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{lo, 3'b000} +: 8];
        h = lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            3'b000:  extend_load = {{24{b[7]}}, b};
            3'b100:  extend_load = {24'h0, b};
            3'b001:  extend_load = {{16{h[15]}}, h};
            3'b101:  extend_load = {16'h0, h};
            default: extend_load = rdata;
        endcase
    endfunction

    // Stage p0: decode of the request presented by the EX/MEM register
    always_comb begin
        access_p0 = i_ctrl_mem_write | i_ctrl_mem2reg;
        store_p0  = i_ctrl_mem_write;
        legal_p0  = access_legal(i_ctrl_word_size, i_alu_result[1:0]);
        o_stall   = ~rst & (((state == IDLE) & access_p0 & legal_p0) | (state == BUSY));
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_q;
    assign o_timeout = tmo_q;
`else
    logic tmo_cfg_unused;
    assign tmo_cfg_unused = |32'(TIMEOUT_CYCLES);
    assign o_timeout      = 1'b0;
`endif

    // Stage p1: bus fields latched for the whole access, result captured on ack
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            o_load_data <= 32'h0;
            o_fault     <= 1'b0;
            o_bus_req   <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_addr  <= 32'h0;
            o_bus_be    <= 4'h0;
            o_bus_wdata <= 32'h0;
            size_p1     <= 3'b000;
            lane_p1     <= 2'b00;
`ifdef LSU_TIMEOUT_EN
            tmo_cnt     <= '0;
            tmo_q       <= 1'b0;
`endif
        end else begin
            o_fault <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            tmo_q   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (access_p0) begin
                        if (legal_p0) begin
                            state       <= BUSY;
                            o_bus_req   <= 1'b1;
                            o_bus_we    <= store_p0;
                            o_bus_addr  <= {i_alu_result[31:2], 2'b00};
                            o_bus_be    <= lane_enables(i_ctrl_word_size, i_alu_result[1:0]);
                            o_bus_wdata <= replicate(i_ctrl_word_size, i_write_data);
                            size_p1     <= i_ctrl_word_size;
                            lane_p1     <= i_alu_result[1:0];
`ifdef LSU_TIMEOUT_EN
                            tmo_cnt     <= '0;
`endif
                        end else begin
                            o_fault     <= 1'b1;
                            o_load_data <= 32'h0;
                        end
                    end
                end
                BUSY: begin
                    if (i_bus_ack) begin
                        state     <= DONE;
                        o_bus_req <= 1'b0;
                        if (!o_bus_we)
                            o_load_data <= extend_load(size_p1, lane_p1, i_bus_rdata);
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        state       <= DONE;
                        o_bus_req   <= 1'b0;
                        o_load_data <= 32'h0;
                        tmo_q       <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: fixed vector table, randomized accesses against a reference model, reset and timeout sequences.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic [31:0] i_alu_result;
    logic [31:0] i_write_data;
    logic        i_ctrl_mem_write;
    logic        i_ctrl_mem2reg;
    logic [2:0]  i_ctrl_word_size;
    logic        o_stall;
    logic [31:0] o_load_data;
    logic        o_fault;
    logic        o_timeout;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [3:0]  o_bus_be;
    logic [31:0] o_bus_wdata;
    logic        i_bus_ack;
    logic [31:0] i_bus_rdata;

    int total = 0;
    int bad   = 0;
    logic [31:0] model_ld;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .i_alu_result(i_alu_result), .i_write_data(i_write_data),
        .i_ctrl_mem_write(i_ctrl_mem_write), .i_ctrl_mem2reg(i_ctrl_mem2reg),
        .i_ctrl_word_size(i_ctrl_word_size),
        .o_stall(o_stall), .o_load_data(o_load_data), .o_fault(o_fault), .o_timeout(o_timeout),
        .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
        .o_bus_be(o_bus_be), .o_bus_wdata(o_bus_wdata),
        .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want test end");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        rd;
        logic [2:0]  sz;
        int          dly;
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_ld;
        logic        e_fault;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] wd, input logic we,
                                input logic rd, input logic [2:0] sz, input int dly,
                                input logic [31:0] rdat, input logic [31:0] ea, input logic [3:0] ebe,
                                input logic [31:0] ewd, input logic [31:0] eld, input logic ef);
        vec_t v;
        v.addr = a; v.wdata = wd; v.we = we; v.rd = rd; v.sz = sz; v.dly = dly; v.rdata = rdat;
        v.e_addr = ea; v.e_be = ebe; v.e_wdata = ewd; v.e_ld = eld; v.e_fault = ef;
        return v;
    endfunction

    // Reference: bytes per access, signedness, alignment by modulo, lanes by shifting.
    function automatic vec_t model(input vec_t v, input logic [31:0] prev_ld);
        vec_t        r;
        int          n;
        bit          sgn;
        bit          legal;
        int          off;
        logic [31:0] sh;
        logic [31:0] mask;
        r   = v;
        n   = 0;
        sgn = 0;
        case (v.sz)
            3'd0: begin n = 1; sgn = 1; end
            3'd4: begin n = 1; sgn = 0; end
            3'd1: begin n = 2; sgn = 1; end
            3'd5: begin n = 2; sgn = 0; end
            3'd2: begin n = 4; sgn = 0; end
            default: n = 0;
        endcase
        off   = int'(v.addr % 4);
        legal = 0;
        if (n != 0) legal = ((off % n) == 0);
        r.e_fault = !legal;
        r.e_addr  = v.addr - 32'(off);
        r.e_be    = 4'h0;
        r.e_wdata = 32'h0;
        if (legal) begin
            r.e_be = 4'(((1 << n) - 1) << off);
            for (int k = 0; k < 4; k++) r.e_wdata[8*k +: 8] = v.wdata[8*(k % n) +: 8];
        end
        if (!legal) r.e_ld = 32'h0;
        else if (v.we) r.e_ld = prev_ld;
        else begin
            sh = v.rdata >> (8 * off);
            if (n == 4) r.e_ld = sh;
            else begin
                mask   = (n == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
                r.e_ld = sh & mask;
                if (sgn && sh[8*n-1]) r.e_ld = r.e_ld | ~mask;
            end
        end
        return r;
    endfunction

    task automatic idle_inputs();
        i_alu_result = 32'h0; i_write_data = 32'h0;
        i_ctrl_mem_write = 1'b0; i_ctrl_mem2reg = 1'b0; i_ctrl_word_size = 3'b000;
        i_bus_ack = 1'b0; i_bus_rdata = 32'h0;
    endtask

    task automatic scramble();
        i_alu_result     = $urandom;
        i_write_data     = $urandom;
        i_ctrl_mem_write = 1'($urandom_range(0, 1));
        i_ctrl_mem2reg   = 1'($urandom_range(0, 1));
        i_ctrl_word_size = 3'($urandom_range(0, 7));
        i_bus_rdata      = $urandom;
    endtask

    task automatic do_access(input vec_t v);
        i_alu_result = v.addr; i_write_data = v.wdata;
        i_ctrl_mem_write = v.we; i_ctrl_mem2reg = v.rd; i_ctrl_word_size = v.sz;
        i_bus_ack = 1'b0; i_bus_rdata = $urandom;
        @(negedge clk);
        chk("idle_stall", 32'(o_stall), 32'(!v.e_fault));
        chk("idle_req", 32'(o_bus_req), 32'd0);
        @(posedge clk); #1;
        if (v.e_fault) begin
            idle_inputs();
            @(negedge clk);
            chk("fault_pulse", 32'(o_fault), 32'd1);
            chk("fault_req_stall", 32'({o_bus_req, o_stall}), 32'd0);
            chk("fault_ld", o_load_data, 32'h0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("fault_once", 32'(o_fault), 32'd0);
            @(posedge clk); #1;
        end else begin
            for (int k = 0; k <= v.dly; k++) begin
                scramble();
                i_bus_ack = (k == v.dly);
                if (k == v.dly) i_bus_rdata = v.rdata;
                @(negedge clk);
                chk("busy_req_stall", 32'({o_bus_req, o_stall}), 32'd3);
                chk("busy_addr", o_bus_addr, v.e_addr);
                chk("busy_be", 32'(o_bus_be), 32'(v.e_be));
                chk("busy_we", 32'(o_bus_we), 32'(v.we));
                if (v.we) chk("busy_wdata", o_bus_wdata, v.e_wdata);
                @(posedge clk); #1;
            end
            scramble();
            i_bus_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("done_stall_req", 32'({o_stall, o_bus_req}), 32'd0);
            chk("done_ld", o_load_data, v.e_ld);
            chk("done_tmo", 32'(o_timeout), 32'd0);
            @(posedge clk); #1;
            idle_inputs();
            @(negedge clk);
            chk("idle_ld_hold", o_load_data, v.e_ld);
            @(posedge clk); #1;
        end
    endtask

    vec_t        tbl[14];
    logic [2:0]  legal_sizes[5];

    initial begin
        tbl[0]  = mk(32'h100, 32'h0,        1'b0, 1'b1, 3'b010, 1, 32'hDEADBEEF, 32'h100, 4'hF, 32'h0,        32'hDEADBEEF, 1'b0);
        tbl[1]  = mk(32'h103, 32'h0,        1'b0, 1'b1, 3'b000, 0, 32'h80FFFFFF, 32'h100, 4'h8, 32'h0,        32'hFFFFFF80, 1'b0);
        tbl[2]  = mk(32'h103, 32'h0,        1'b0, 1'b1, 3'b100, 0, 32'h80FFFFFF, 32'h100, 4'h8, 32'h0,        32'h00000080, 1'b0);
        tbl[3]  = mk(32'h202, 32'h1234ABCD, 1'b1, 1'b0, 3'b001, 0, 32'h0,        32'h200, 4'hC, 32'hABCDABCD, 32'h00000080, 1'b0);
        tbl[4]  = mk(32'h101, 32'h0,        1'b0, 1'b1, 3'b010, 0, 32'h0,        32'h0,   4'h0, 32'h0,        32'h0,        1'b1);
        tbl[5]  = mk(32'h001, 32'h000000A5, 1'b1, 1'b0, 3'b000, 3, 32'h0,        32'h0,   4'h2, 32'hA5A5A5A5, 32'h0,        1'b0);
        tbl[6]  = mk(32'h006, 32'h0,        1'b0, 1'b1, 3'b001, 0, 32'h80011234, 32'h4,   4'hC, 32'h0,        32'hFFFF8001, 1'b0);
        tbl[7]  = mk(32'h006, 32'h0,        1'b0, 1'b1, 3'b101, 2, 32'h80011234, 32'h4,   4'hC, 32'h0,        32'h00008001, 1'b0);
        tbl[8]  = mk(32'h10C, 32'hCAFEF00D, 1'b1, 1'b0, 3'b010, 2, 32'h0,        32'h10C, 4'hF, 32'hCAFEF00D, 32'h00008001, 1'b0);
        tbl[9]  = mk(32'h000, 32'h0,        1'b0, 1'b1, 3'b011, 0, 32'h0,        32'h0,   4'h0, 32'h0,        32'h0,        1'b1);
        tbl[10] = mk(32'h020, 32'h11223344, 1'b1, 1'b1, 3'b010, 1, 32'h99999999, 32'h20,  4'hF, 32'h11223344, 32'h0,        1'b0);
        tbl[11] = mk(32'h003, 32'h0,        1'b0, 1'b1, 3'b001, 0, 32'h0,        32'h0,   4'h0, 32'h0,        32'h0,        1'b1);
        tbl[12] = mk(32'h102, 32'h0,        1'b0, 1'b1, 3'b000, 0, 32'h007F0000, 32'h100, 4'h4, 32'h0,        32'h0000007F, 1'b0);
        tbl[13] = mk(32'h010, 32'h55,       1'b1, 1'b0, 3'b110, 0, 32'h0,        32'h0,   4'h0, 32'h0,        32'h0,        1'b1);
        legal_sizes[0] = 3'd0; legal_sizes[1] = 3'd1; legal_sizes[2] = 3'd2;
        legal_sizes[3] = 3'd4; legal_sizes[4] = 3'd5;

        // Reset with a legal access and a stray ack present
        rst = 1'b1;
        idle_inputs();
        i_alu_result = 32'h100; i_ctrl_mem2reg = 1'b1; i_ctrl_word_size = 3'b010;
        i_bus_ack = 1'b1; i_bus_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_stall", 32'(o_stall), 32'd0);
        chk("rst_ctrl", 32'({o_bus_req, o_bus_we, o_fault, o_timeout}), 32'd0);
        chk("rst_addr", o_bus_addr, 32'h0);
        chk("rst_be", 32'(o_bus_be), 32'd0);
        chk("rst_wdata", o_bus_wdata, 32'h0);
        chk("rst_ld", o_load_data, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        i_bus_ack = 1'b1; i_bus_rdata = 32'h12345678;
        @(negedge clk);
        chk("post_rst_req", 32'({o_bus_req, o_stall}), 32'd0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("stray_ack_ld", o_load_data, 32'h0);
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) do_access(tbl[i]);
        model_ld = tbl[13].e_ld;

        for (int i = 0; i < 60; i++) begin
            vec_t v;
            int   pick;
            v.addr  = $urandom;
            v.wdata = $urandom;
            v.rdata = $urandom;
            v.dly   = $urandom_range(0, 3);
            case ($urandom_range(0, 2))
                0:       begin v.we = 1'b1; v.rd = 1'b0; end
                1:       begin v.we = 1'b0; v.rd = 1'b1; end
                default: begin v.we = 1'b1; v.rd = 1'b1; end
            endcase
            pick = $urandom_range(0, 11);
            if (pick < 10) v.sz = legal_sizes[pick % 5];
            else if (pick == 10) v.sz = 3'd3;
            else v.sz = 3'($urandom_range(6, 7));
            if ($urandom_range(0, 1) == 1) v.addr[1:0] = 2'b00;
            v = model(v, model_ld);
            model_ld = v.e_ld;
            do_access(v);
        end

        // Reset in the second BUSY cycle with an ack in that same cycle
        do_access(mk(32'h40, 32'h0, 1'b0, 1'b1, 3'b010, 0, 32'h12345678, 32'h40, 4'hF, 32'h0, 32'h12345678, 1'b0));
        i_alu_result = 32'h80; i_ctrl_mem2reg = 1'b1; i_ctrl_word_size = 3'b010;
        @(posedge clk); #1;
        scramble();
        i_bus_ack = 1'b0;
        @(negedge clk);
        chk("rb_busy_req", 32'(o_bus_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        i_bus_ack = 1'b1;
        i_bus_rdata = 32'hFFFF0000;
        @(negedge clk);
        chk("rb_stall_in_rst", 32'(o_stall), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        chk("rb_req_stall", 32'({o_bus_req, o_stall}), 32'd0);
        chk("rb_ld", o_load_data, 32'h0);
        chk("rb_addr_be", {o_bus_addr[27:0], o_bus_be}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rb_no_done_ld", o_load_data, 32'h0);
        @(posedge clk); #1;

        // Bus that never acknowledges
        i_alu_result = 32'h0; i_ctrl_mem2reg = 1'b1; i_ctrl_word_size = 3'b010;
        do_access(mk(32'h44, 32'h0, 1'b0, 1'b1, 3'b010, 0, 32'hA5A50001, 32'h44, 4'hF, 32'h0, 32'hA5A50001, 1'b0));
        i_alu_result = 32'h0; i_ctrl_mem2reg = 1'b1; i_ctrl_word_size = 3'b010;
        @(posedge clk); #1;
`ifdef LSU_TIMEOUT_EN
        for (int k = 0; k < 4; k++) begin
            scramble();
            i_bus_ack = 1'b0;
            @(negedge clk);
            chk("to_busy", 32'({o_bus_req, o_stall, o_timeout}), 32'd6);
            @(posedge clk); #1;
        end
        idle_inputs();
        @(negedge clk);
        chk("to_pulse", 32'(o_timeout), 32'd1);
        chk("to_done", 32'({o_stall, o_bus_req}), 32'd0);
        chk("to_ld", o_load_data, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("to_once", 32'(o_timeout), 32'd0);
        @(posedge clk); #1;
`else
        for (int k = 0; k < 20; k++) begin
            scramble();
            i_bus_ack = 1'b0;
            @(negedge clk);
            chk("wait_busy", 32'({o_bus_req, o_stall, o_timeout}), 32'd6);
            @(posedge clk); #1;
        end
        i_bus_ack = 1'b1;
        i_bus_rdata = 32'h0BADF00D;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("wait_done_ld", o_load_data, 32'h0BADF00D);
        chk("wait_done", 32'({o_stall, o_bus_req, o_timeout}), 32'd0);
        @(posedge clk); #1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
